// File: rtl/mem_access_unit_pkg.sv
// Shared types for the memory access unit: request/response format and sizing constants.
package mem_access_unit_pkg;

    localparam int NUM_OF_CORES      = 4;
    localparam int CORE_ID_W         = $clog2(NUM_OF_CORES);
    localparam int DATA_W            = 32;
    localparam int LEN_W             = 8;
    localparam int MEM_WORDS_DEFAULT = 1024;
    localparam int MEM_ADDR_W        = $clog2(MEM_WORDS_DEFAULT);

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1
    } opcode_e;

    typedef struct packed {
        logic                  vld;
        logic [CORE_ID_W-1:0]  core_id;
        logic [LEN_W-1:0]      access_length;
        opcode_e               opcode;
        logic [MEM_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } request_t;

endpackage

// File: rtl/mem_access_unit_req_fifo.sv
// Synchronous request FIFO; full is registered and a push while full is dropped.
module req_fifo
    import mem_access_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  request_t                 din_i,
    output request_t                 dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    request_t         store_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q;
    logic             do_push, do_pop;

    assign do_push = push_i && !full_q;
    assign do_pop  = pop_i && (count_q != '0);

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == CNT_W'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) store_q[wr_ptr_q] <= din_i;
    end

    assign dout_o  = store_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/mem_access_unit.sv
// Memory-side access unit: buffers requests and runs them as word bursts on an on-chip array.
// Define MEM_ACCESS_PERF_EN to add saturating read/write/drop counters.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int REQ_DEPTH  = 4,
    parameter int MEM_WORDS  = MEM_WORDS_DEFAULT,
    parameter int RD_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  request_t    mem_req,
    output logic        mem_req_full,
    output request_t    mem_rsp
`ifdef MEM_ACCESS_PERF_EN
    ,
    output logic [31:0] rd_beat_cnt,
    output logic [31:0] wr_beat_cnt,
    output logic [15:0] drop_cnt
`endif
);
    localparam int ADDR_W = $clog2(MEM_WORDS);
    localparam int CNT_W  = $clog2(REQ_DEPTH) + 1;
    localparam int LAST   = RD_LATENCY - 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;
    state_e state_q, state_d;

    request_t              fifo_head;
    logic                  fifo_full, fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic                  pop, rd_issue, wr_en, ack_emit, bad_emit;

    logic [CORE_ID_W-1:0]  work_core_q;
    opcode_e               work_op_q;
    logic [MEM_ADDR_W-1:0] work_addr_q;
    logic [DATA_W-1:0]     work_data_q;
    logic [LEN_W-1:0]      beats_q, beat_q;
    logic [ADDR_W-1:0]     beat_addr;
    logic                  last_beat;

    logic [DATA_W-1:0]     mem_q       [MEM_WORDS];
    logic [RD_LATENCY-1:0] pipe_vld_q;
    logic [ADDR_W-1:0]     pipe_addr_q [RD_LATENCY];
    logic [CORE_ID_W-1:0]  pipe_core_q [RD_LATENCY];
    logic [DATA_W-1:0]     pipe_data_q [RD_LATENCY];
    request_t              mem_rsp_d, mem_rsp_q;

    req_fifo #(.DEPTH(REQ_DEPTH)) u_req_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (mem_req.vld),
        .pop_i   (pop),
        .din_i   (mem_req),
        .dout_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign beat_addr = ADDR_W'(work_addr_q) + ADDR_W'(beat_q);
    assign last_beat = (beat_q == beats_q - 1'b1);

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (!fifo_empty && fifo_head.vld) state_d = ISSUE;
            ISSUE: begin
                case (work_op_q)
                    OP_READ:  if (last_beat) state_d = DRAIN;
                    OP_WRITE: if (last_beat) state_d = IDLE;
                    default:  state_d = IDLE;
                endcase
            end
            DRAIN: if (pipe_vld_q == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pop      = 1'b0;
        rd_issue = 1'b0;
        wr_en    = 1'b0;
        ack_emit = 1'b0;
        bad_emit = 1'b0;
        case (state_q)
            IDLE:  pop = (fifo_count != '0) && fifo_head.vld;
            ISSUE: begin
                case (work_op_q)
                    OP_READ:  rd_issue = 1'b1;
                    OP_WRITE: begin
                        wr_en    = 1'b1;
                        ack_emit = last_beat;
                    end
                    default:  bad_emit = 1'b1;
                endcase
            end
            default: ;
        endcase
    end

    // Read beats and acks never coincide: writes only start once the read pipeline has drained.
    always_comb begin
        mem_rsp_d = '0;
        if (pipe_vld_q[LAST]) begin
            mem_rsp_d.vld     = 1'b1;
            mem_rsp_d.core_id = pipe_core_q[LAST];
            mem_rsp_d.opcode  = OP_READ;
            mem_rsp_d.addr    = MEM_ADDR_W'(pipe_addr_q[LAST]);
            mem_rsp_d.data    = pipe_data_q[LAST];
        end else if (ack_emit || bad_emit) begin
            mem_rsp_d.vld     = 1'b1;
            mem_rsp_d.core_id = work_core_q;
            mem_rsp_d.opcode  = work_op_q;
            mem_rsp_d.addr    = work_addr_q;
            mem_rsp_d.data    = bad_emit ? '1 : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            work_core_q <= '0;
            work_op_q   <= OP_READ;
            work_addr_q <= '0;
            work_data_q <= '0;
            beats_q     <= '0;
            beat_q      <= '0;
            pipe_vld_q  <= '0;
            mem_rsp_q   <= '0;
            for (int unsigned i = 0; i < RD_LATENCY; i++) begin
                pipe_addr_q[i] <= '0;
                pipe_core_q[i] <= '0;
            end
        end else begin
            if (pop) begin
                work_core_q <= fifo_head.core_id;
                work_op_q   <= fifo_head.opcode;
                work_addr_q <= fifo_head.addr;
                work_data_q <= fifo_head.data;
                beats_q     <= (fifo_head.access_length == '0) ? LEN_W'(1) : fifo_head.access_length;
                beat_q      <= '0;
            end else if (rd_issue || wr_en) begin
                beat_q <= beat_q + 1'b1;
            end
            pipe_vld_q[0]  <= rd_issue;
            pipe_addr_q[0] <= beat_addr;
            pipe_core_q[0] <= work_core_q;
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                pipe_vld_q[i]  <= pipe_vld_q[i-1];
                pipe_addr_q[i] <= pipe_addr_q[i-1];
                pipe_core_q[i] <= pipe_core_q[i-1];
            end
            mem_rsp_q <= mem_rsp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[beat_addr] <= work_data_q;
        pipe_data_q[0] <= mem_q[beat_addr];
        for (int unsigned i = 1; i < RD_LATENCY; i++) begin
            pipe_data_q[i] <= pipe_data_q[i-1];
        end
    end

    assign mem_rsp      = mem_rsp_q;
    assign mem_req_full = fifo_full;

`ifdef MEM_ACCESS_PERF_EN
    logic [31:0] rd_beat_cnt_q, wr_beat_cnt_q;
    logic [15:0] drop_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_beat_cnt_q <= '0;
            wr_beat_cnt_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            if (rd_issue && rd_beat_cnt_q != '1) rd_beat_cnt_q <= rd_beat_cnt_q + 1'b1;
            if (wr_en && wr_beat_cnt_q != '1)    wr_beat_cnt_q <= wr_beat_cnt_q + 1'b1;
            if (mem_req.vld && fifo_full && drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
        end
    end

    assign rd_beat_cnt = rd_beat_cnt_q;
    assign wr_beat_cnt = wr_beat_cnt_q;
    assign drop_cnt    = drop_cnt_q;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit against a word-array/response-queue reference model.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    localparam int MW = MEM_WORDS_DEFAULT;

    logic     clk = 1'b0;
    logic     reset;
    request_t mem_req;
    logic     mem_req_full;
    request_t mem_rsp;
`ifdef MEM_ACCESS_PERF_EN
    logic [31:0] rd_beat_cnt, wr_beat_cnt;
    logic [15:0] drop_cnt;
`endif

    mem_access_unit #(.REQ_DEPTH(4), .MEM_WORDS(MW), .RD_LATENCY(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_req      (mem_req),
        .mem_req_full (mem_req_full),
        .mem_rsp      (mem_rsp)
`ifdef MEM_ACCESS_PERF_EN
        ,
        .rd_beat_cnt  (rd_beat_cnt),
        .wr_beat_cnt  (wr_beat_cnt),
        .drop_cnt     (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int push_cyc;

    logic [DATA_W-1:0] model_mem [MW];
    request_t expq[$];
    request_t rxq[$];
    int       rx_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_rsp.vld === 1'b1) begin
            rxq.push_back(mem_rsp);
            rx_cyc.push_back(cyc);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, observed=running required=finished");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, want);
        end
    endtask

    function automatic logic [63:0] pack(input request_t r);
        return 64'({r.vld, r.core_id, r.opcode, r.addr, r.data});
    endfunction

    function automatic request_t mk(input opcode_e op, input int core, input int addr,
                                    input int len, input logic [DATA_W-1:0] data);
        request_t r;
        r = '0;
        r.vld           = 1'b1;
        r.core_id       = CORE_ID_W'(core);
        r.opcode        = op;
        r.addr          = MEM_ADDR_W'(addr);
        r.access_length = LEN_W'(len);
        r.data          = data;
        return r;
    endfunction

    // Reference: what the request means, beat by beat, with plain modular addressing.
    task automatic model_apply(input request_t r);
        int       n;
        int       a;
        request_t e;
        n = (r.access_length == 0) ? 1 : int'(r.access_length);
        e = '0;
        e.vld     = 1'b1;
        e.core_id = r.core_id;
        e.opcode  = r.opcode;
        if (r.opcode == OP_WRITE) begin
            for (int i = 0; i < n; i++) model_mem[(int'(r.addr) + i) % MW] = r.data;
            e.addr = r.addr;
            e.data = '0;
            expq.push_back(e);
        end else if (r.opcode == OP_READ) begin
            for (int i = 0; i < n; i++) begin
                a = (int'(r.addr) + i) % MW;
                e.addr = MEM_ADDR_W'(a);
                e.data = model_mem[a];
                expq.push_back(e);
            end
        end else begin
            e.addr = r.addr;
            e.data = '1;
            expq.push_back(e);
        end
    endtask

    task automatic send(input request_t r, input bit accept);
        @(negedge clk);
        mem_req = r;
        @(posedge clk);
        #1;
        push_cyc = cyc;
        mem_req  = '0;
        if (accept) model_apply(r);
    endtask

    task automatic drain_check(input string tag, input int budget, output int first_cyc, output bit consec);
        int n;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            #1;
            if (rxq.size() >= expq.size()) break;
        end
        repeat (6) @(negedge clk);
        #1;
        chk({tag, "_count"}, 64'(rxq.size()), 64'(expq.size()));
        first_cyc = (rx_cyc.size() > 0) ? rx_cyc[0] : -1;
        consec = 1'b1;
        for (int i = 1; i < rx_cyc.size(); i++) if (rx_cyc[i] != rx_cyc[i-1] + 1) consec = 1'b0;
        n = (rxq.size() < expq.size()) ? rxq.size() : expq.size();
        for (int i = 0; i < n; i++) chk($sformatf("%s_rsp%0d", tag, i), pack(rxq[i]), pack(expq[i]));
        rxq.delete();
        rx_cyc.delete();
        expq.delete();
    endtask

    initial begin
        int  fc;
        bit  cs;
        int  addr, len, rlen;
        logic [DATA_W-1:0] d;

        mem_req = '0;
        reset   = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_rsp", 64'(mem_rsp), 64'd0);
        chk("reset_full", 64'(mem_req_full), 64'd0);
`ifdef MEM_ACCESS_PERF_EN
        chk("reset_rdcnt", 64'(rd_beat_cnt), 64'd0);
        chk("reset_dropcnt", 64'(drop_cnt), 64'd0);
`endif
        reset = 1'b0;

        // Write then read with latency check
        send(mk(OP_WRITE, 1, 'h10, 1, 'hA5), 1'b1);
        drain_check("wr_ack", 50, fc, cs);
        send(mk(OP_READ, 2, 'h10, 1, '0), 1'b1);
        drain_check("rd_single", 50, fc, cs);
        chk("rd_latency", 64'(fc), 64'(push_cyc + 4));

        // Burst read
        for (int i = 0; i < 4; i++) send(mk(OP_WRITE, i, 'h20 + i, 1, DATA_W'(i + 1)), 1'b1);
        drain_check("burst_fill", 100, fc, cs);
        send(mk(OP_READ, 3, 'h20, 4, '0), 1'b1);
        drain_check("burst_rd", 100, fc, cs);
        chk("burst_consec", 64'(cs), 64'd1);

        // Address wrap
        send(mk(OP_WRITE, 0, MW - 2, 4, 'h7), 1'b1);
        drain_check("wrap_wr", 50, fc, cs);
        send(mk(OP_READ, 1, MW - 2, 4, '0), 1'b1);
        drain_check("wrap_rd", 50, fc, cs);

        // Length zero, bad opcode
        send(mk(OP_WRITE, 2, 'h50, 1, 'hCAFE), 1'b1);
        drain_check("bad_pre", 50, fc, cs);
        send(mk(OP_READ, 0, 'h50, 0, '0), 1'b1);
        drain_check("len0", 50, fc, cs);
        send(mk(opcode_e'(2'd2), 1, 'h50, 1, 'h1234), 1'b1);
        drain_check("badop", 50, fc, cs);
        send(mk(OP_READ, 3, 'h50, 1, '0), 1'b1);
        drain_check("badop_nowr", 50, fc, cs);

        // Randomised write/read-back pairs queued back to back
        for (int it = 0; it < 8; it++) begin
            addr = $urandom_range('h200, 'h300);
            len  = $urandom_range(0, 6);
            rlen = $urandom_range(0, (len == 0) ? 1 : len);
            d    = $urandom;
            send(mk(OP_WRITE, $urandom_range(0, 3), addr, len, d), 1'b1);
            send(mk(OP_READ, $urandom_range(0, 3), addr, rlen, '0), 1'b1);
            drain_check($sformatf("rand%0d", it), 100, fc, cs);
        end

        // Full and drop behind a long read
        send(mk(OP_WRITE, 0, 'h100, 255, $urandom), 1'b1);
        drain_check("long_fill", 400, fc, cs);
        send(mk(OP_READ, 0, 'h100, 255, '0), 1'b1);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            send(mk(OP_READ, $urandom_range(0, 3), 'h100 + i, 1, '0), 1'b1);
            if (i == 2) chk("full_after3", 64'(mem_req_full), 64'd0);
        end
        chk("full_after4", 64'(mem_req_full), 64'd1);
        send(mk(OP_READ, 1, 'h150, 1, '0), 1'b0);
`ifdef MEM_ACCESS_PERF_EN
        chk("drop_cnt", 64'(drop_cnt), 64'd1);
`endif
        drain_check("full_drain", 700, fc, cs);
        chk("full_cleared", 64'(mem_req_full), 64'd0);

        // Reset in the middle of a burst
        send(mk(OP_WRITE, 0, 'h180, 8, $urandom), 1'b1);
        drain_check("mid_fill", 50, fc, cs);
        send(mk(OP_READ, 3, 'h180, 8, '0), 1'b1);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            #1;
            if (rxq.size() >= 3) break;
        end
        reset = 1'b1;
        @(negedge clk);
        #1;
        reset = 1'b0;
        chk("mid_rst_vld", 64'(mem_rsp.vld), 64'd0);
        chk("mid_rst_full", 64'(mem_req_full), 64'd0);
`ifdef MEM_ACCESS_PERF_EN
        chk("mid_rst_rdcnt", 64'(rd_beat_cnt), 64'd0);
`endif
        repeat (20) @(negedge clk);
        #1;
        chk("mid_rst_count", 64'(rxq.size()), 64'd3);
        for (int i = 0; i < 3 && i < rxq.size(); i++) chk($sformatf("mid_rsp%0d", i), pack(rxq[i]), pack(expq[i]));
        rxq.delete();
        rx_cyc.delete();
        expq.delete();
        send(mk(OP_READ, 2, 'h181, 2, '0), 1'b1);
        drain_check("post_rst", 50, fc, cs);
        chk("post_rst_latency", 64'(fc), 64'(push_cyc + 4));
`ifdef MEM_ACCESS_PERF_EN
        chk("post_rdcnt", 64'(rd_beat_cnt), 64'd2);
        chk("post_wrcnt", 64'(wr_beat_cnt), 64'd0);
        chk("post_dropcnt", 64'(drop_cnt), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
